// File: rtl/lfsr_pkg.sv
// Shared PRBS definitions for the LFSR generator and checker.
// Default polynomial is x^8+x^6+x^5+x^4+1.
package lfsr_pkg;

  localparam int         N_DEF    = 8;
  localparam logic [7:0] TAPS_DEF = 8'hB8;

  typedef enum logic {
    SEED,
    LOCKED
  } chk_state_t;

endpackage

// File: rtl/lfsr_predict.sv
// Next-bit prediction of a Fibonacci LFSR.
// Shared by generator and checker so both use one polynomial.
module lfsr_predict
  import lfsr_pkg::*;
#(
  parameter int         N    = N_DEF,
  parameter logic [N-1:0] TAPS = TAPS_DEF
) (
  input  logic [N-1:0] s,
  output logic         p
);

  assign p = ^(s & TAPS);

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: self-seeds from the stream,
// then free-runs and counts mismatches with lock-loss detection.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int           N    = N_DEF,
  parameter logic [N-1:0] TAPS = TAPS_DEF,
  parameter int           CW   = 16,
  parameter int           WIN  = 32,
  parameter int           THR  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_bit,
  input  logic          clr,
  output logic          locked,
  output logic          err,
  output logic          lock_lost,
  output logic [CW-1:0] err_cnt,
  output logic          sat
);

  localparam int SW = $clog2(N);
  localparam int WW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int EW = $clog2(THR + 1);

  localparam logic [SW-1:0] SEED_LAST = SW'(N - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WIN - 1);
  localparam logic [EW-1:0] THR_V     = EW'(THR);

  chk_state_t    state, state_n;
  logic [N-1:0]  s, s_n;
  logic [SW-1:0] seed_cnt, seed_n;
  logic [WW-1:0] win_cnt, win_n;
  logic [EW-1:0] win_err, werr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          err_q, err_n;
  logic          lost_q, lost_n;
  logic          p;
  logic          mism;
  logic          wrap;

  lfsr_predict #(
    .N    (N),
    .TAPS (TAPS)
  ) u_pred (
    .s (s),
    .p (p)
  );

  // Next-state: seeding, free-run compare, window and counter.
  always_comb begin
    state_n = state;
    s_n     = s;
    seed_n  = seed_cnt;
    win_n   = win_cnt;
    werr_n  = win_err;
    cnt_n   = cnt;
    err_n   = 1'b0;
    lost_n  = 1'b0;
    mism    = 1'b0;
    wrap    = 1'b0;
    if (in_valid) begin
      unique case (state)
        SEED: begin
          s_n = {s[N-2:0], in_bit};
          if (seed_cnt == SEED_LAST) begin
            seed_n = '0;
            if (|s_n) state_n = LOCKED;
          end else begin
            seed_n = seed_cnt + 1'b1;
          end
        end
        LOCKED: begin
          mism   = in_bit ^ p;
          s_n    = {s[N-2:0], p};
          wrap   = (win_cnt == WIN_LAST);
          win_n  = wrap ? '0 : win_cnt + 1'b1;
          werr_n = wrap ? EW'(mism)
                        : win_err + EW'(mism);
          err_n  = mism;
          if (mism && !sat) cnt_n = cnt + 1'b1;
          if (mism && werr_n == THR_V) begin
            state_n = SEED;
            s_n     = '0;
            seed_n  = '0;
            win_n   = '0;
            werr_n  = '0;
            lost_n  = 1'b1;
          end
        end
        default: state_n = SEED;
      endcase
    end
    if (clr) cnt_n = '0;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SEED;
      s        <= '0;
      seed_cnt <= '0;
      win_cnt  <= '0;
      win_err  <= '0;
      cnt      <= '0;
      err_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state    <= state_n;
      s        <= s_n;
      seed_cnt <= seed_n;
      win_cnt  <= win_n;
      win_err  <= werr_n;
      cnt      <= cnt_n;
      err_q    <= err_n;
      lost_q   <= lost_n;
    end
  end

  assign locked    = (state == LOCKED);
  assign err       = err_q;
  assign lock_lost = lost_q;
  assign err_cnt   = cnt;
  assign sat       = &cnt;

endmodule
